// File: rtl/gpio_bank_if.sv
// gpio_bank_if: control strobes and register select for the GPIO bank.
// The shared data bus is not part of this interface. It is a resolved tri-state net
// that is connected straight to the bank's data_bus port.
//   CS        chip select
//   mem_read  read strobe
//   mem_write write strobe
//   addr      register select (3 bits)
// Modports: master drives the strobes, slave (the bank) receives them.
interface gpio_bank_if;
  logic       CS;
  logic       mem_read;
  logic       mem_write;
  logic [2:0] addr;

  modport master (output CS, output mem_read, output mem_write, output addr);
  modport slave  (input CS, input mem_read, input mem_write, input addr);
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank.
// Features:
//   - per-pin direction
//   - 2-flop input synchroniser
//   - per-pin rising/falling edge capture into sticky write-1-to-clear STATUS bits
//   - level interrupt irq = |STATUS
// Optional macro GPIO_DEBOUNCE_EN adds a per-pin debounce filter between the
// synchroniser and the edge detector.
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous, active-high reset
//   bus       gpio_bank_if.slave (CS, mem_read, mem_write, addr)
//   data_bus  shared tri-state data bus, driven only during a read
//   IO        GPIO pins, driven when DIR=1, otherwise Z
//   irq       level interrupt, active high
// Register map:
//   0 DATA     read: sampled pins; write: output register
//   1 DIR      1 = output
//   2 RISE_EN  rising-edge capture enable
//   3 FALL_EN  falling-edge capture enable
//   4 STATUS   sticky edge flags; write 1 to clear
//   5-7        read as 0; writes are ignored
module gpio_bank #(
  parameter int N_IO       = 13,
  parameter int BUS_W      = 64,
  parameter int DEB_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  gpio_bank_if.slave        bus,
  inout  wire  [BUS_W-1:0]  data_bus,
  inout  wire  [N_IO-1:0]   IO,
  output logic              irq
);

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_DIR     = 3'd1;
  localparam logic [2:0] A_RISE_EN = 3'd2;
  localparam logic [2:0] A_FALL_EN = 3'd3;
  localparam logic [2:0] A_STATUS  = 3'd4;

  if (N_IO < 1 || N_IO > BUS_W || DEB_CYCLES < 2) begin : g_bad_params
    $error("gpio_bank: illegal parameter combination");
  end

  logic             rd_en;
  logic             wr_en;
  logic [N_IO-1:0]  out_reg;
  logic [N_IO-1:0]  dir_reg;
  logic [N_IO-1:0]  rise_en;
  logic [N_IO-1:0]  fall_en;
  logic [N_IO-1:0]  status;
  logic [N_IO-1:0]  sync_meta;
  logic [N_IO-1:0]  sync;
  logic [N_IO-1:0]  in_q;
  logic [N_IO-1:0]  prev;
  logic [N_IO-1:0]  wr_val;
  logic [N_IO-1:0]  clr_mask;
  logic [N_IO-1:0]  edge_hit;
  logic [BUS_W-1:0] rd_data;
  logic             unused_bus_bits;

  // A simultaneous read and write strobe is treated as no access at all.
  assign rd_en = bus.CS & bus.mem_read & ~bus.mem_write;
  assign wr_en = bus.CS & bus.mem_write & ~bus.mem_read;

  assign wr_val          = data_bus[N_IO-1:0];
  assign unused_bus_bits = ^data_bus;

  always_comb begin
    rd_data = '0;
    unique case (bus.addr)
      A_DATA:    rd_data[N_IO-1:0] = in_q;
      A_DIR:     rd_data[N_IO-1:0] = dir_reg;
      A_RISE_EN: rd_data[N_IO-1:0] = rise_en;
      A_FALL_EN: rd_data[N_IO-1:0] = fall_en;
      A_STATUS:  rd_data[N_IO-1:0] = status;
      default:   rd_data = '0;
    endcase
  end

  assign data_bus = rd_en ? rd_data : {BUS_W{1'bz}};

  for (genvar i = 0; i < N_IO; i++) begin : g_pin_drive
    assign IO[i] = dir_reg[i] ? out_reg[i] : 1'bz;
  end

  // Pins are sampled whatever their direction, so outputs produce edges too.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= IO;
      sync      <= sync_meta;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int              CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] deb_cnt [N_IO];

  // A pin only moves in_q after it has disagreed with in_q for DEB_CYCLES
  // consecutive cycles. Any return to agreement restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_q <= '0;
      for (int i = 0; i < N_IO; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_IO; i++) begin
        if (sync[i] != in_q[i]) begin
          if (deb_cnt[i] == CNT_LAST) begin
            in_q[i]    <= sync[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign in_q = sync;
`endif

  assign edge_hit = (in_q & ~prev & rise_en) | (~in_q & prev & fall_en);
  assign clr_mask = (wr_en && bus.addr == A_STATUS) ? wr_val : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_reg <= '0;
      dir_reg <= '0;
      rise_en <= '0;
      fall_en <= '0;
      status  <= '0;
      prev    <= '0;
    end else begin
      prev <= in_q;
      // A new edge in the same cycle as a clear keeps the bit set.
      status <= (status & ~clr_mask) | edge_hit;
      if (wr_en) begin
        unique case (bus.addr)
          A_DATA:    out_reg <= wr_val;
          A_DIR:     dir_reg <= wr_val;
          A_RISE_EN: rise_en <= wr_val;
          A_FALL_EN: fall_en <= wr_val;
          default:   ;
        endcase
      end
    end
  end

  assign irq = |status;

endmodule
